// File: rtl/mor1kx_wb_latch_marocchino_pkg.sv
// Shared constants for the MAROCCHINO write-back latch: FPCSR layout and
// the positions of the SR bits held by this stage.
package mor1kx_wb_latch_marocchino_pkg;

  localparam int FPCSR_WIDTH     = 12;
  localparam int FPCSR_FPEE      = 0;
  localparam int FPCSR_RM_LSB    = 1;
  localparam int FPCSR_RM_MSB    = 2;
  localparam int FPCSR_FLAGS_LSB = 3;
  localparam int FPCSR_FLAGS_MSB = 11;

  // Indices into the 3-bit vector of SR bits owned by write-back.
  localparam int SR_F  = 0;
  localparam int SR_CY = 1;
  localparam int SR_OV = 2;
  localparam int SR_NUM_BITS = 3;

  // Exception flags accumulate; FPEE and RM are left untouched.
  function automatic logic [FPCSR_WIDTH-1:0] fpcsr_merge_flags(
    input logic [FPCSR_WIDTH-1:0] cur,
    input logic [FPCSR_WIDTH-1:0] upd
  );
    return {cur[FPCSR_FLAGS_MSB:FPCSR_FLAGS_LSB] | upd[FPCSR_FLAGS_MSB:FPCSR_FLAGS_LSB],
            cur[FPCSR_RM_MSB:FPCSR_RM_LSB],
            cur[FPCSR_FPEE]};
  endfunction

endpackage

// File: rtl/mor1kx_sr_bit_marocchino.sv
// One architectural SR bit: control-unit write beats the execute set/clear
// strobes, set beats clear. A disabled bit is tied to zero.
module mor1kx_sr_bit_marocchino #(
  parameter bit ENABLE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_we_i,
  input  logic ctrl_val_i,
  input  logic exec_upd_i,
  input  logic set_i,
  input  logic clear_i,
  output logic bit_o
);

  if (ENABLE) begin : g_bit
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge value of its inputs, independent of block evaluation order.
    always_ff @(posedge clk) begin
      if (rst)
        bit_o <= 1'b0;
      else if (ctrl_we_i)
        bit_o <= ctrl_val_i;
      else if (exec_upd_i & set_i)
        bit_o <= 1'b1;
      else if (exec_upd_i & clear_i)
        bit_o <= 1'b0;
    end
  end else begin : g_tied
    assign bit_o = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, clk, rst, ctrl_we_i, ctrl_val_i,
                             exec_upd_i, set_i, clear_i};
  end

endmodule

// File: rtl/mor1kx_wb_latch_marocchino.sv
// Write-back pipeline register: latches the execute/load result and
// destination, owns SR[F/CY/OV] and FPCSR, and drives decode forwarding.
module mor1kx_wb_latch_marocchino
  import mor1kx_wb_latch_marocchino_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter     FEATURE_OVERFLOW     = "NONE",
  parameter     FEATURE_CARRY_FLAG   = "ENABLED",
  parameter     FEATURE_FPU          = "NONE"
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_wb_i,
  input  logic                            pipeline_flush_i,
  input  logic                            exec_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] exec_result_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i,
  input  logic                            op_lsu_load_i,
  input  logic                            exec_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i,
  input  logic                            exec_flag_set_i,
  input  logic                            exec_flag_clear_i,
  input  logic                            exec_carry_set_i,
  input  logic                            exec_carry_clear_i,
  input  logic                            exec_overflow_set_i,
  input  logic                            exec_overflow_clear_i,
  input  logic [FPCSR_WIDTH-1:0]          exec_fpcsr_i,
  input  logic                            exec_fpcsr_set_i,
  input  logic                            ctrl_sr_we_i,
  input  logic                            ctrl_sr_f_i,
  input  logic                            ctrl_sr_cy_i,
  input  logic                            ctrl_sr_ov_i,
  input  logic                            ctrl_fpcsr_we_i,
  input  logic [FPCSR_WIDTH-1:0]          ctrl_fpcsr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] dcod_rfb_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o,
  output logic                            wb_rf_we_o,
  output logic                            wb_valid_o,
  output logic                            wb_fwd_a_o,
  output logic                            wb_fwd_b_o,
  output logic                            sr_flag_o,
  output logic                            sr_carry_o,
  output logic                            sr_overflow_o,
  output logic [FPCSR_WIDTH-1:0]          fpcsr_o
);

  // A flushed instruction never reaches write-back, so it updates nothing.
  logic cap;
  assign cap = padv_wb_i & exec_valid_i & ~pipeline_flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_result_o  <= '0;
      wb_rfd_adr_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_rf_we_o   <= 1'b0;
    end else begin
      wb_valid_o <= cap;
      wb_rf_we_o <= cap & exec_rf_wb_i;
      if (cap) begin
        wb_result_o  <= op_lsu_load_i ? lsu_result_i : exec_result_i;
        wb_rfd_adr_o <= exec_rfd_adr_i;
      end
    end
  end

  logic [SR_NUM_BITS-1:0] sr_bits;

  mor1kx_sr_bit_marocchino #(.ENABLE(1'b1)) u_sr_flag (
    .clk        (clk),
    .rst        (rst),
    .ctrl_we_i  (ctrl_sr_we_i),
    .ctrl_val_i (ctrl_sr_f_i),
    .exec_upd_i (cap),
    .set_i      (exec_flag_set_i),
    .clear_i    (exec_flag_clear_i),
    .bit_o      (sr_bits[SR_F])
  );

  mor1kx_sr_bit_marocchino #(.ENABLE(FEATURE_CARRY_FLAG != "NONE")) u_sr_carry (
    .clk        (clk),
    .rst        (rst),
    .ctrl_we_i  (ctrl_sr_we_i),
    .ctrl_val_i (ctrl_sr_cy_i),
    .exec_upd_i (cap),
    .set_i      (exec_carry_set_i),
    .clear_i    (exec_carry_clear_i),
    .bit_o      (sr_bits[SR_CY])
  );

  mor1kx_sr_bit_marocchino #(.ENABLE(FEATURE_OVERFLOW != "NONE")) u_sr_overflow (
    .clk        (clk),
    .rst        (rst),
    .ctrl_we_i  (ctrl_sr_we_i),
    .ctrl_val_i (ctrl_sr_ov_i),
    .exec_upd_i (cap),
    .set_i      (exec_overflow_set_i),
    .clear_i    (exec_overflow_clear_i),
    .bit_o      (sr_bits[SR_OV])
  );

  assign sr_flag_o     = sr_bits[SR_F];
  assign sr_carry_o    = sr_bits[SR_CY];
  assign sr_overflow_o = sr_bits[SR_OV];

  if (FEATURE_FPU != "NONE") begin : g_fpcsr
    // An MTSPR to FPCSR overrides any flags raised in the same cycle.
    always_ff @(posedge clk) begin
      if (rst)
        fpcsr_o <= '0;
      else if (ctrl_fpcsr_we_i)
        fpcsr_o <= ctrl_fpcsr_i;
      else if (cap & exec_fpcsr_set_i)
        fpcsr_o <= fpcsr_merge_flags(fpcsr_o, exec_fpcsr_i);
    end
  end else begin : g_no_fpcsr
    assign fpcsr_o = '0;

    logic unused_fpcsr_inputs;
    assign unused_fpcsr_inputs = &{1'b0, exec_fpcsr_i, exec_fpcsr_set_i,
                                   ctrl_fpcsr_we_i, ctrl_fpcsr_i};
  end

  // r0 reads as zero architecturally, so it is never a forwarding target.
  assign wb_fwd_a_o = wb_rf_we_o & (wb_rfd_adr_o == dcod_rfa_adr_i) & (|dcod_rfa_adr_i);
  assign wb_fwd_b_o = wb_rf_we_o & (wb_rfd_adr_o == dcod_rfb_adr_i) & (|dcod_rfb_adr_i);

endmodule

// File: tb/tb_mor1kx_wb_latch_marocchino.sv
// Scoreboard bench for the write-back latch: a driver applies directed and
// random stimulus and queues the predicted outputs; a monitor compares.
module tb_mor1kx_wb_latch_marocchino;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv_wb_i, pipeline_flush_i, exec_valid_i;
  logic [31:0] exec_result_i, lsu_result_i;
  logic        op_lsu_load_i, exec_rf_wb_i;
  logic [4:0]  exec_rfd_adr_i;
  logic        exec_flag_set_i, exec_flag_clear_i;
  logic        exec_carry_set_i, exec_carry_clear_i;
  logic        exec_overflow_set_i, exec_overflow_clear_i;
  logic [11:0] exec_fpcsr_i;
  logic        exec_fpcsr_set_i;
  logic        ctrl_sr_we_i, ctrl_sr_f_i, ctrl_sr_cy_i, ctrl_sr_ov_i;
  logic        ctrl_fpcsr_we_i;
  logic [11:0] ctrl_fpcsr_i;
  logic [4:0]  dcod_rfa_adr_i, dcod_rfb_adr_i;
  logic [31:0] wb_result_o;
  logic [4:0]  wb_rfd_adr_o;
  logic        wb_rf_we_o, wb_valid_o, wb_fwd_a_o, wb_fwd_b_o;
  logic        sr_flag_o, sr_carry_o, sr_overflow_o;
  logic [11:0] fpcsr_o;

  always #5 clk = ~clk;

  mor1kx_wb_latch_marocchino #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5),
    .FEATURE_OVERFLOW     ("NONE"),
    .FEATURE_CARRY_FLAG   ("ENABLED"),
    .FEATURE_FPU          ("ENABLED")
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .padv_wb_i             (padv_wb_i),
    .pipeline_flush_i      (pipeline_flush_i),
    .exec_valid_i          (exec_valid_i),
    .exec_result_i         (exec_result_i),
    .lsu_result_i          (lsu_result_i),
    .op_lsu_load_i         (op_lsu_load_i),
    .exec_rf_wb_i          (exec_rf_wb_i),
    .exec_rfd_adr_i        (exec_rfd_adr_i),
    .exec_flag_set_i       (exec_flag_set_i),
    .exec_flag_clear_i     (exec_flag_clear_i),
    .exec_carry_set_i      (exec_carry_set_i),
    .exec_carry_clear_i    (exec_carry_clear_i),
    .exec_overflow_set_i   (exec_overflow_set_i),
    .exec_overflow_clear_i (exec_overflow_clear_i),
    .exec_fpcsr_i          (exec_fpcsr_i),
    .exec_fpcsr_set_i      (exec_fpcsr_set_i),
    .ctrl_sr_we_i          (ctrl_sr_we_i),
    .ctrl_sr_f_i           (ctrl_sr_f_i),
    .ctrl_sr_cy_i          (ctrl_sr_cy_i),
    .ctrl_sr_ov_i          (ctrl_sr_ov_i),
    .ctrl_fpcsr_we_i       (ctrl_fpcsr_we_i),
    .ctrl_fpcsr_i          (ctrl_fpcsr_i),
    .dcod_rfa_adr_i        (dcod_rfa_adr_i),
    .dcod_rfb_adr_i        (dcod_rfb_adr_i),
    .wb_result_o           (wb_result_o),
    .wb_rfd_adr_o          (wb_rfd_adr_o),
    .wb_rf_we_o            (wb_rf_we_o),
    .wb_valid_o            (wb_valid_o),
    .wb_fwd_a_o            (wb_fwd_a_o),
    .wb_fwd_b_o            (wb_fwd_b_o),
    .sr_flag_o             (sr_flag_o),
    .sr_carry_o            (sr_carry_o),
    .sr_overflow_o         (sr_overflow_o),
    .fpcsr_o               (fpcsr_o)
  );

  typedef struct packed {
    logic        rst, padv, flush, valid;
    logic [31:0] exec_res, lsu_res;
    logic        load, rf_wb;
    logic [4:0]  rfd;
    logic        fset, fclr, cset, cclr, oset, oclr;
    logic [11:0] exec_fpcsr;
    logic        fpcsr_set;
    logic        sr_we, sr_f, sr_cy, sr_ov;
    logic        fpcsr_we;
    logic [11:0] ctrl_fpcsr;
    logic [4:0]  rfa, rfb;
  } stim_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  adr;
    logic        we, valid, fwd_a, fwd_b, f, cy, ov;
    logic [11:0] fpcsr;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Architectural behaviour of one clock edge, expressed from the rules.
  task automatic apply(input stim_t s);
    exp_t n;
    bit   cap;
    @(negedge clk);
    rst = s.rst; padv_wb_i = s.padv; pipeline_flush_i = s.flush;
    exec_valid_i = s.valid; exec_result_i = s.exec_res; lsu_result_i = s.lsu_res;
    op_lsu_load_i = s.load; exec_rf_wb_i = s.rf_wb; exec_rfd_adr_i = s.rfd;
    exec_flag_set_i = s.fset; exec_flag_clear_i = s.fclr;
    exec_carry_set_i = s.cset; exec_carry_clear_i = s.cclr;
    exec_overflow_set_i = s.oset; exec_overflow_clear_i = s.oclr;
    exec_fpcsr_i = s.exec_fpcsr; exec_fpcsr_set_i = s.fpcsr_set;
    ctrl_sr_we_i = s.sr_we; ctrl_sr_f_i = s.sr_f; ctrl_sr_cy_i = s.sr_cy;
    ctrl_sr_ov_i = s.sr_ov; ctrl_fpcsr_we_i = s.fpcsr_we; ctrl_fpcsr_i = s.ctrl_fpcsr;
    dcod_rfa_adr_i = s.rfa; dcod_rfb_adr_i = s.rfb;

    n = model;
    if (s.rst) begin
      n = '0;
    end else begin
      cap     = s.padv && s.valid && !s.flush;
      n.valid = cap;
      n.we    = cap && s.rf_wb;
      if (cap) begin
        n.result = s.load ? s.lsu_res : s.exec_res;
        n.adr    = s.rfd;
      end
      if (s.sr_we)                      n.f = s.sr_f;
      else if (cap && (s.fset || s.fclr)) n.f = s.fset;
      if (s.sr_we)                      n.cy = s.sr_cy;
      else if (cap && (s.cset || s.cclr)) n.cy = s.cset;
      n.ov = 1'b0;
      if (s.fpcsr_we)                   n.fpcsr = s.ctrl_fpcsr;
      else if (cap && s.fpcsr_set)      n.fpcsr = model.fpcsr | (s.exec_fpcsr & 12'hff8);
    end
    n.fwd_a = n.we && (n.adr == s.rfa) && (s.rfa != 0);
    n.fwd_b = n.we && (n.adr == s.rfb) && (s.rfb != 0);
    model = n;
    exp_q.push_back(n);
  endtask

  // Monitor: one prediction is due after every clock edge that follows a drive.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wb_result",   wb_result_o,   e.result);
        check("wb_rfd_adr",  32'(wb_rfd_adr_o), 32'(e.adr));
        check("wb_rf_we",    32'(wb_rf_we_o),   32'(e.we));
        check("wb_valid",    32'(wb_valid_o),   32'(e.valid));
        check("wb_fwd_a",    32'(wb_fwd_a_o),   32'(e.fwd_a));
        check("wb_fwd_b",    32'(wb_fwd_b_o),   32'(e.fwd_b));
        check("sr_flag",     32'(sr_flag_o),    32'(e.f));
        check("sr_carry",    32'(sr_carry_o),   32'(e.cy));
        check("sr_overflow", 32'(sr_overflow_o), 32'(e.ov));
        check("fpcsr",       32'(fpcsr_o),      32'(e.fpcsr));
      end
    end
  end

  function automatic stim_t cap_stim(input logic [31:0] res, input logic [4:0] rfd);
    stim_t s = '0;
    s.padv = 1'b1; s.valid = 1'b1; s.rf_wb = 1'b1;
    s.exec_res = res; s.rfd = rfd;
    return s;
  endfunction

  initial begin
    stim_t s;
    model = '0;
    s = '0; s.rst = 1'b1;
    apply(s); apply(s);

    // Result path, one-cycle write strobe, then load-data select.
    apply(cap_stim(32'h12345678, 5'd5));
    s = '0; apply(s);
    s = cap_stim(32'h11111111, 5'd6); s.load = 1'b1; s.lsu_res = 32'hCAFEF00D;
    apply(s);
    s = '0; apply(s);

    // Flush blocks capture and SR strobes.
    s = cap_stim(32'hAAAA5555, 5'd9); s.flush = 1'b1; s.fset = 1'b1; apply(s);
    s = cap_stim(32'h1, 5'd1); s.fset = 1'b1; s.cset = 1'b1; apply(s);
    s = cap_stim(32'h2, 5'd2); s.flush = 1'b1; s.fclr = 1'b1; s.cclr = 1'b1; apply(s);

    // SR priority and disabled overflow.
    s = cap_stim(32'h3, 5'd3); s.fset = 1'b1; s.sr_we = 1'b1; s.sr_f = 1'b0; s.sr_cy = 1'b1;
    apply(s);
    s = cap_stim(32'h4, 5'd4); s.fset = 1'b1; s.fclr = 1'b1; s.cset = 1'b1; s.cclr = 1'b1;
    apply(s);
    s = cap_stim(32'h5, 5'd4); s.oset = 1'b1; apply(s);
    s = '0; s.sr_we = 1'b1; s.sr_ov = 1'b1; apply(s);

    // FPCSR sticky accumulation and ctrl override.
    s = cap_stim(32'h6, 5'd6); s.fpcsr_set = 1'b1; s.exec_fpcsr = 12'h008; apply(s);
    s = cap_stim(32'h7, 5'd6); s.fpcsr_set = 1'b1; s.exec_fpcsr = 12'h100; apply(s);
    s = cap_stim(32'h8, 5'd6); s.fpcsr_set = 1'b1; s.exec_fpcsr = 12'h200;
    s.fpcsr_we = 1'b1; s.ctrl_fpcsr = 12'h002; apply(s);

    // Forwarding, including the r0 exclusion.
    s = cap_stim(32'h77, 5'd7); s.rfa = 5'd7; s.rfb = 5'd8; apply(s);
    s = cap_stim(32'h00, 5'd0); s.rfa = 5'd0; s.rfb = 5'd0; apply(s);
    s = cap_stim(32'h88, 5'd8); s.rfa = 5'd1; s.rfb = 5'd8; apply(s);

    // Reset mid-operation.
    s = cap_stim(32'hDEADBEEF, 5'd3); s.fset = 1'b1; s.fpcsr_set = 1'b1;
    s.exec_fpcsr = 12'hFF8; apply(s);
    s = '0; s.rst = 1'b1; apply(s);

    for (int i = 0; i < 3000; i++) begin
      s.rst        = ($urandom_range(0, 99) == 0);
      s.padv       = ($urandom_range(0, 3) != 0);
      s.flush      = ($urandom_range(0, 7) == 0);
      s.valid      = ($urandom_range(0, 3) != 0);
      s.exec_res   = $urandom;
      s.lsu_res    = $urandom;
      s.load       = ($urandom_range(0, 3) == 0);
      s.rf_wb      = ($urandom_range(0, 3) != 0);
      s.rfd        = 5'($urandom_range(0, 7));
      s.fset       = ($urandom_range(0, 3) == 0);
      s.fclr       = ($urandom_range(0, 3) == 0);
      s.cset       = ($urandom_range(0, 3) == 0);
      s.cclr       = ($urandom_range(0, 3) == 0);
      s.oset       = ($urandom_range(0, 3) == 0);
      s.oclr       = ($urandom_range(0, 3) == 0);
      s.exec_fpcsr = 12'($urandom);
      s.fpcsr_set  = ($urandom_range(0, 2) == 0);
      s.sr_we      = ($urandom_range(0, 7) == 0);
      s.sr_f       = 1'($urandom);
      s.sr_cy      = 1'($urandom);
      s.sr_ov      = 1'($urandom);
      s.fpcsr_we   = ($urandom_range(0, 15) == 0);
      s.ctrl_fpcsr = 12'($urandom);
      s.rfa        = 5'($urandom_range(0, 7));
      s.rfb        = 5'($urandom_range(0, 7));
      apply(s);
    end

    s = '0; apply(s);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
